uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between NUM_REQ independent byte sources, e.g. a command echo path, a status reporter and a debug dumper.
- Arbitrates round-robin, captures the winning byte and issues one write pulse to the transmitter.
- Tracks the transmitter busy flag through to frame completion before granting the next byte.
- Sits between the requesters and the transmitter's data_in/wr_en/Tx_busy pins inside the UART top level.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_if.sv | 37 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 104 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART arbiter definitions: FSM state encoding, data width and a one-hot to index helper.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } arb_state_t;

  // Up to 8 requesters, so a fixed 8-bit view covers every legal NUM_REQ.
  function automatic logic [2:0] oh_idx(input logic [7:0] oh);
    oh_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) oh_idx = 3'(i);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter. req_lock exists only when
// UART_TX_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if import uart_pkg::*; #(
  parameter int NUM_REQ = 4
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0][UART_DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]                  req_ready;
`ifdef UART_TX_ARB_LOCK_EN
  logic [NUM_REQ-1:0]                  req_lock;
`endif
  logic [UART_DATA_W-1:0]              tx_data;
  logic                                tx_wr_en;
  logic                                tx_busy;
  logic [ID_W-1:0]                     grant_id;
  logic                                arb_busy;
  logic                                tx_err;

  modport master (
    output req_valid, req_data, tx_busy,
`ifdef UART_TX_ARB_LOCK_EN
    output req_lock,
`endif
    input  req_ready, tx_data, tx_wr_en, grant_id, arb_busy, tx_err
  );

  modport slave (
    input  req_valid, req_data, tx_busy,
`ifdef UART_TX_ARB_LOCK_EN
    input  req_lock,
`endif
    output req_ready, tx_data, tx_wr_en, grant_id, arb_busy, tx_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first set request strictly after ptr, with wrap.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 vld
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    // off = N revisits ptr itself last, so the previous winner has lowest priority.
    for (int off = 1; off <= N; off++) begin
      idx = IW'((int'(ptr) + off) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign vld = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources.
// Optional UART_TX_ARB_LOCK_EN lets a locked grantee keep the transmitter for multi-byte packets.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input logic              clk_50m,
  input logic              clear,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [ID_W-1:0]    ptr;
  logic [7:0]         cnt;
  logic [NUM_REQ-1:0] rr_gnt;
  logic               rr_vld;
  logic [ID_W-1:0]    rr_idx;
  logic [ID_W-1:0]    win;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (rr_gnt),
    .vld (rr_vld)
  );

  assign rr_idx = ID_W'(oh_idx(8'(rr_gnt)));

`ifdef UART_TX_ARB_LOCK_EN
  logic lock_hold;
  // A lock sampled on the way back to IDLE only sticks while its owner still has a byte.
  assign win = (lock_hold && bus.req_valid[bus.grant_id]) ? bus.grant_id : rr_idx;
`else
  assign win = rr_idx;
`endif

  always_ff @(posedge clk_50m or posedge clear) begin
    if (clear) begin
      state         <= ST_IDLE;
      ptr           <= ID_W'(NUM_REQ - 1);
      cnt           <= 8'd0;
      bus.req_ready <= '0;
      bus.tx_data   <= '0;
      bus.tx_wr_en  <= 1'b0;
      bus.grant_id  <= '0;
      bus.arb_busy  <= 1'b0;
      bus.tx_err    <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_hold     <= 1'b0;
`endif
    end else begin
      bus.req_ready <= '0;
      bus.tx_wr_en  <= 1'b0;
      bus.tx_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Waiting on tx_busy also covers a reset that landed mid-frame.
          if (rr_vld && !bus.tx_busy) begin
            state         <= ST_ISSUE;
            bus.tx_data   <= bus.req_data[win];
            bus.grant_id  <= win;
            ptr           <= win;
            bus.req_ready <= NUM_REQ'(1) << win;
            bus.tx_wr_en  <= 1'b1;
            bus.arb_busy  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT_START;
          cnt   <= 8'd0;
        end
        ST_WAIT_START: begin
          if (bus.tx_busy) begin
            state <= ST_WAIT_DONE;
            cnt   <= 8'd0;
          end else if (cnt == 8'(BUSY_TIMEOUT - 1)) begin
            // Byte is dropped, not retried; the requester already saw ready.
            state        <= ST_IDLE;
            cnt          <= 8'd0;
            bus.tx_err   <= 1'b1;
            bus.arb_busy <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_hold    <= bus.req_lock[bus.grant_id];
`endif
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            state        <= ST_IDLE;
            bus.arb_busy <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_hold    <= bus.req_lock[bus.grant_id];
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 20-cycle transmitter busy model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ = 4;

  logic clk_50m = 1'b0;
  logic clear;
  always #10 clk_50m = ~clk_50m;

  uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NREQ), .BUSY_TIMEOUT(15)) dut (
    .clk_50m (clk_50m),
    .clear   (clear),
    .bus     (bus)
  );

  // Transmitter model: busy from the edge after wr_en, for 20 cycles.
  int busy_cnt = 0;
  bit model_en = 1'b1;
  bit busy_force = 1'b0;
  always @(posedge clk_50m) begin
    if (model_en && bus.tx_wr_en) busy_cnt <= 20;
    else if (busy_cnt > 0)        busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (busy_cnt != 0) || busy_force;

  int cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  logic [7:0] wr_data[$];
  int         wr_gid[$];
  int wr_cyc = 0, err_cyc = 0, err_cnt = 0, multi_rdy = 0, rdy_bad = 0;
  always @(negedge clk_50m) begin
    if (bus.tx_wr_en) begin
      wr_data.push_back(bus.tx_data);
      wr_gid.push_back(int'(bus.grant_id));
      wr_cyc <= cyc;
      if (bus.req_ready != (NREQ'(1) << bus.grant_id)) rdy_bad <= rdy_bad + 1;
    end else if (bus.req_ready != '0) begin
      rdy_bad <= rdy_bad + 1;
    end
    if ($countones(bus.req_ready) > 1) multi_rdy <= multi_rdy + 1;
    if (bus.tx_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic wait_wr(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (wr_data.size() >= n) break;
      step();
    end
    ok = (wr_data.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!bus.arb_busy && !bus.tx_busy) break;
      step();
    end
    ok = !bus.arb_busy && !bus.tx_busy;
  endtask

  task automatic pulse_clear();
    #3 clear = 1'b1;
    #3 clear = 1'b0;
    step();
  endtask

  task automatic test_reset();
    clear         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
`ifdef UART_TX_ARB_LOCK_EN
    bus.req_lock  = '0;
`endif
    #25;
    total++; if (bus.req_ready !== 4'b0)  begin bad++; $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready); end
    total++; if (bus.tx_wr_en !== 1'b0)   begin bad++; $display("FAIL reset_tx_wr_en got=%b want=0", bus.tx_wr_en); end
    total++; if (bus.tx_data !== 8'h00)   begin bad++; $display("FAIL reset_tx_data got=%h want=00", bus.tx_data); end
    total++; if (bus.grant_id !== 2'd0)   begin bad++; $display("FAIL reset_grant_id got=%0d want=0", bus.grant_id); end
    total++; if (bus.arb_busy !== 1'b0)   begin bad++; $display("FAIL reset_arb_busy got=%b want=0", bus.arb_busy); end
    total++; if (bus.tx_err !== 1'b0)     begin bad++; $display("FAIL reset_tx_err got=%b want=0", bus.tx_err); end
    #2 clear = 1'b0;
    step(); step();
  endtask

  task automatic test_single();
    bit found, seen_busy, ok;
    int n;
    wr_data.delete(); wr_gid.delete();
    bus.req_data[0] = 8'hA5;
    bus.req_valid   = 4'b0001;
    found = 1'b0; n = 0;
    for (int i = 0; i < 10; i++) begin
      step(); n++;
      if (bus.tx_wr_en) begin found = 1'b1; break; end
    end
    total++; if (!found)                 begin bad++; $display("FAIL single_wr_seen got=none want=pulse"); end
    total++; if (n != 1)                 begin bad++; $display("FAIL single_latency got=%0d want=1", n); end
    total++; if (bus.tx_data !== 8'hA5)  begin bad++; $display("FAIL single_tx_data got=%h want=a5", bus.tx_data); end
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL single_req_ready got=%b want=0001", bus.req_ready); end
    total++; if (bus.grant_id !== 2'd0)  begin bad++; $display("FAIL single_grant_id got=%0d want=0", bus.grant_id); end
    bus.req_valid = '0;
    seen_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.tx_busy) seen_busy = 1'b1;
      if (seen_busy && !bus.tx_busy) break;
    end
    total++; if (!seen_busy || bus.tx_busy) begin bad++; $display("FAIL single_busy_cycle got=seen%0b/busy%0b want=seen1/busy0", seen_busy, bus.tx_busy); end
    total++; if (bus.arb_busy !== 1'b1)  begin bad++; $display("FAIL single_arb_busy_hold got=%b want=1", bus.arb_busy); end
    step();
    total++; if (bus.arb_busy !== 1'b0)  begin bad++; $display("FAIL single_arb_busy_fall got=%b want=0", bus.arb_busy); end
    total++; if (wr_data.size() != 1)    begin bad++; $display("FAIL single_wr_count got=%0d want=1", wr_data.size()); end
    bus.req_data[0] = 8'h11;
    wait_idle(20, ok);
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    int mr0, rb0;
    bit ok;
    pulse_clear();
    wr_data.delete(); wr_gid.delete();
    mr0 = multi_rdy; rb0 = rdy_bad;
    bus.req_valid = 4'b1111;
    wait_wr(5, 200, ok);
    bus.req_valid = '0;
    total++; if (!ok) begin bad++; $display("FAIL rr_wr_count got=%0d want=5", wr_data.size()); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (wr_data[i] !== exp_d[i]) begin bad++; $display("FAIL rr_order[%0d] got=%h want=%h", i, wr_data[i], exp_d[i]); end
    end
    wait_idle(40, ok);
    total++; if (multi_rdy != mr0) begin bad++; $display("FAIL rr_multi_ready got=%0d want=0", multi_rdy - mr0); end
    total++; if (rdy_bad != rb0)   begin bad++; $display("FAIL rr_ready_vs_wr got=%0d want=0", rdy_bad - rb0); end
  endtask

  task automatic test_skip_granted();
    bit ok;
    wr_data.delete(); wr_gid.delete();
    bus.req_valid = 4'b0100;
    wait_wr(1, 40, ok);
    bus.req_valid = 4'b0101;
    wait_wr(2, 60, ok);
    bus.req_valid = 4'b0100;
    wait_wr(3, 60, ok);
    bus.req_valid = '0;
    total++; if (wr_gid.size() != 3 || wr_gid[0] != 2) begin bad++; $display("FAIL skip_first got=%0d want=2", wr_gid[0]); end
    total++; if (wr_gid[1] != 0)       begin bad++; $display("FAIL skip_next_grant got=%0d want=0", wr_gid[1]); end
    total++; if (wr_data[1] !== 8'h11) begin bad++; $display("FAIL skip_next_data got=%h want=11", wr_data[1]); end
    total++; if (wr_gid[2] != 2)       begin bad++; $display("FAIL skip_third got=%0d want=2", wr_gid[2]); end
    wait_idle(40, ok);
  endtask

  task automatic test_timeout();
    int ec0;
    bit ok;
    wr_data.delete(); wr_gid.delete();
    ec0 = err_cnt;
    model_en = 1'b0;
    bus.req_valid = 4'b0010;
    wait_wr(1, 10, ok);
    bus.req_valid = '0;
    for (int i = 0; i < 40; i++) begin
      if (err_cnt > ec0) break;
      step();
    end
    step(); step(); step();
    total++; if (wr_gid[0] != 1)          begin bad++; $display("FAIL to_grant got=%0d want=1", wr_gid[0]); end
    total++; if (err_cnt - ec0 != 1)      begin bad++; $display("FAIL to_err_pulses got=%0d want=1", err_cnt - ec0); end
    total++; if (err_cyc - wr_cyc != 16)  begin bad++; $display("FAIL to_err_delay got=%0d want=16", err_cyc - wr_cyc); end
    total++; if (bus.arb_busy !== 1'b0)   begin bad++; $display("FAIL to_idle got=%b want=0", bus.arb_busy); end
    model_en = 1'b1;
    bus.req_valid = 4'b1000;
    wait_wr(2, 10, ok);
    bus.req_valid = '0;
    total++; if (!ok || wr_gid[1] != 3)   begin bad++; $display("FAIL to_next_grant got=%0d want=3", wr_gid[1]); end
    total++; if (wr_data[1] !== 8'h44)    begin bad++; $display("FAIL to_next_data got=%h want=44", wr_data[1]); end
    wait_idle(40, ok);
    total++; if (err_cnt - ec0 != 1)      begin bad++; $display("FAIL to_no_second_err got=%0d want=1", err_cnt - ec0); end
  endtask

  task automatic test_clear_mid_frame();
    int base;
    bit ok;
    wr_data.delete(); wr_gid.delete();
    bus.req_valid = 4'b0001;
    wait_wr(1, 10, ok);
    bus.req_valid = '0;
    for (int i = 0; i < 5; i++) step();
    busy_force    = 1'b1;
    bus.req_valid = 4'b0010;
    #5 clear = 1'b1;
    #1;
    total++; if (bus.arb_busy !== 1'b0)  begin bad++; $display("FAIL clr_arb_busy got=%b want=0", bus.arb_busy); end
    total++; if (bus.tx_data !== 8'h00)  begin bad++; $display("FAIL clr_tx_data got=%h want=00", bus.tx_data); end
    total++; if (bus.grant_id !== 2'd0)  begin bad++; $display("FAIL clr_grant_id got=%0d want=0", bus.grant_id); end
    #2 clear = 1'b0;
    base = wr_data.size();
    for (int i = 0; i < 10; i++) step();
    busy_force = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.tx_busy) break;
      step();
    end
    total++; if (wr_data.size() != base) begin bad++; $display("FAIL clr_wr_while_busy got=%0d want=0", wr_data.size() - base); end
    wait_wr(base + 1, 10, ok);
    bus.req_valid = '0;
    total++; if (!ok || wr_gid[base] != 1) begin bad++; $display("FAIL clr_next_grant got=%0d want=1", wr_gid[base]); end
    total++; if (wr_data[base] !== 8'h22)  begin bad++; $display("FAIL clr_next_data got=%h want=22", wr_data[base]); end
    wait_idle(40, ok);
  endtask

`ifdef UART_TX_ARB_LOCK_EN
  task automatic test_lock();
    int exp_g[4] = '{1, 1, 1, 0};
    bit ok;
    wr_data.delete(); wr_gid.delete();
    bus.req_lock  = 4'b0010;
    bus.req_valid = 4'b0010;
    wait_wr(1, 10, ok);
    bus.req_valid = 4'b0011;
    wait_wr(3, 80, ok);
    bus.req_lock  = '0;
    bus.req_valid = 4'b0001;
    wait_wr(4, 40, ok);
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wr_gid[i] != exp_g[i]) begin bad++; $display("FAIL lock_order[%0d] got=%0d want=%0d", i, wr_gid[i], exp_g[i]); end
    end
    wait_idle(40, ok);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_skip_granted();
    test_timeout();
    test_clear_mid_frame();
`ifdef UART_TX_ARB_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
